des_round_sequencer: RTL and testbench

Iterative DES core controller. It accepts one post-IP block (L0, R0) plus an encrypt/decrypt flag, and runs it through a single shared round-function instance for ROUNDS iterations. Each iteration it requests the subkey for the current round from the external key schedule and captures the round-function result. When all rounds are done it presents the swapped pre-output (R16, L16) to the downstream FP stage over a valid/ready handshake.

---
 rtl/des_round_sequencer.sv | 153 +++++++++++++++
 tb/tb_des_round_sequencer.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// -----------------------------------------------------------------------------
// des_round_sequencer
//
// Iterative DES datapath controller. Accepts one post-IP block (L0, R0) and an
// encrypt/decrypt flag, then drives a single external round-function instance
// ROUNDS times. Each round it presents the working halves plus the subkey for
// the current round index, and waits for the round-function result. When all
// rounds are done it presents the swapped pre-output (R16, L16) downstream.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   s_valid/s_ready       upstream handshake; s_L/s_R block, s_decrypt mode
//   m_valid/m_ready       downstream handshake; m_L = R16, m_R = L16
//   round_idx, key_i      subkey request to / subkey from the key schedule
//   rf_valid, rf_L/R/K    round-function inputs (rf_K is key_i passed through)
//   rf_o_valid, rf_*_out  round-function result
//   busy                  high whenever not idle
//   err                   sticky round-function timeout flag
// -----------------------------------------------------------------------------
module des_round_sequencer #(
    parameter int ROUNDS   = 16,
    parameter int WAIT_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [1:32] s_L,
    input  logic [1:32] s_R,
    input  logic        s_decrypt,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [1:32] m_L,
    output logic [1:32] m_R,
    output logic [3:0]  round_idx,
    input  logic [1:48] key_i,
    output logic        rf_valid,
    output logic [1:32] rf_L,
    output logic [1:32] rf_R,
    output logic [1:48] rf_K,
    input  logic        rf_o_valid,
    input  logic [1:32] rf_L_out,
    input  logic [1:32] rf_R_out,
    output logic        busy,
    output logic        err
);

    // Wait counter only needs to reach WAIT_MAX-1.
    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [3:0]    LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [1:32]   l_q, l_d;
    logic [1:32]   r_q, r_d;
    logic          mode_q, mode_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            l_q     <= '0;
            r_q     <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            l_q     <= l_d;
            r_q     <= r_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        l_d     = l_q;
        r_d     = r_q;
        mode_d  = mode_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    l_d     = s_L;
                    r_d     = s_R;
                    mode_d  = s_decrypt;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (rf_o_valid) begin
                    l_d = rf_L_out;
                    r_d = rf_R_out;
                    if (cnt_q == LAST_ROUND) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ISSUE;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Round function never answered: drop the block.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready   = (state_q == IDLE);
    assign m_valid   = (state_q == DONE);
    assign rf_valid  = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign rf_L      = l_q;
    assign rf_R      = r_q;
    assign rf_K      = key_i;
    // Decryption walks the subkeys from the last round back to the first.
    assign round_idx = mode_q ? (LAST_ROUND - cnt_q) : cnt_q;
    // Final swap: pre-output is (R16, L16).
    assign m_L       = r_q;
    assign m_R       = l_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_round_sequencer
//
// Drives des_round_sequencer with a behavioural DES key schedule and round
// function. Expected pre-outputs come from a plain 16-round DES loop; expected
// subkey indices and pre-outputs are queued at accept time and consumed by an
// independent monitor whenever the DUT issues a round or presents a result.
// -----------------------------------------------------------------------------
module tb_des_round_sequencer;

    localparam int ROUNDS   = 16;
    localparam int WAIT_MAX = 4;

    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };
    localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                                60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                                29,21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic        clk, rst_n;
    logic        s_valid, s_ready, s_decrypt;
    logic [31:0] s_L, s_R;
    logic        m_valid, m_ready;
    logic [31:0] m_L, m_R;
    logic [3:0]  round_idx;
    logic [47:0] key_i;
    logic        rf_valid;
    logic [31:0] rf_L, rf_R;
    logic [47:0] rf_K;
    logic        rf_o_valid;
    logic [31:0] rf_L_out, rf_R_out;
    logic        busy, err;

    logic [47:0] subkeys [16];
    assign key_i = subkeys[round_idx];

    des_round_sequencer #(.ROUNDS(ROUNDS), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_L(s_L), .s_R(s_R), .s_decrypt(s_decrypt),
        .m_valid(m_valid), .m_ready(m_ready), .m_L(m_L), .m_R(m_R),
        .round_idx(round_idx), .key_i(key_i),
        .rf_valid(rf_valid), .rf_L(rf_L), .rf_R(rf_R), .rf_K(rf_K),
        .rf_o_valid(rf_o_valid), .rf_L_out(rf_L_out), .rf_R_out(rf_R_out),
        .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Bench controls
    logic rf_hang = 1'b0;      // round function never answers
    int   rf_lat_max = 1;      // round-function latency drawn from 1..rf_lat_max
    logic stray_en = 1'b0;     // spurious rf_o_valid pulses while not waiting
    logic mr_rand = 1'b0;      // random m_ready
    logic mr_force0 = 1'b0;    // hold m_ready low

    logic [31:0] last_ml, last_mr;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          acc;
    } exp_t;
    exp_t exp_q[$];
    int   idx_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // DES f function: expansion, key mix, S-boxes, permutation P.
    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        logic [5:0]  b;
        int          row, col;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int i = 0; i < 8; i++) begin
            b   = e[47-6*i -: 6];
            row = {b[5], b[0]};
            col = int'(b[4:1]);
            s[31-4*i -: 4] = 4'(SBOX[i][row*16+col]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    // Reference: full Feistel loop; returns {pre-output left, pre-output right}.
    function automatic logic [63:0] ref_des(input logic [31:0] l0, input logic [31:0] r0, input logic dec);
        logic [31:0] l, r, t;
        l = l0;
        r = r0;
        for (int i = 0; i < ROUNDS; i++) begin
            t = r;
            r = l ^ f_func(r, subkeys[dec ? (ROUNDS - 1 - i) : i]);
            l = t;
        end
        return {r, l};
    endfunction

    // Round-function stub: samples a request mid-cycle, answers after a random latency.
    initial begin : rf_stub
        logic        issue, stray;
        logic [31:0] nl, nr, pl, pr;
        int          cd, lat;
        cd = 0;
        pl = '0;
        pr = '0;
        rf_o_valid = 1'b0;
        rf_L_out = '0;
        rf_R_out = '0;
        forever begin
            @(negedge clk);
            issue = rf_valid && !rf_hang;
            nl    = rf_R;
            nr    = rf_L ^ f_func(rf_R, rf_K);
            stray = stray_en && m_valid && ($urandom_range(2, 0) == 0);
            @(posedge clk);
            #1;
            rf_o_valid = 1'b0;
            rf_L_out   = $urandom;
            rf_R_out   = $urandom;
            if (issue) begin
                lat = $urandom_range(rf_lat_max, 1);
                if (lat == 1) begin
                    rf_o_valid = 1'b1;
                    rf_L_out   = nl;
                    rf_R_out   = nr;
                end else begin
                    cd = lat - 1;
                    pl = nl;
                    pr = nr;
                end
            end else if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    rf_o_valid = 1'b1;
                    rf_L_out   = pl;
                    rf_R_out   = pr;
                end
            end else if (stray) begin
                rf_o_valid = 1'b1;
            end
        end
    end

    initial begin : mready_drv
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mr_force0)    m_ready = 1'b0;
            else if (mr_rand) m_ready = 1'($urandom_range(1, 0));
            else              m_ready = 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        logic        prev_hold, prev_mv;
        logic [31:0] held_l, held_r;
        logic [63:0] res;
        exp_t        e;
        int          ei;
        prev_hold = 1'b0;
        prev_mv   = 1'b0;
        held_l    = '0;
        held_r    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
                prev_mv   = 1'b0;
            end else begin
                if (s_valid && s_ready) begin
                    if (!rf_hang) begin
                        res   = ref_des(s_L, s_R, s_decrypt);
                        e.l   = res[63:32];
                        e.r   = res[31:0];
                        e.acc = cyc + 1;
                        exp_q.push_back(e);
                        for (int i = 0; i < ROUNDS; i++)
                            idx_q.push_back(s_decrypt ? (ROUNDS - 1 - i) : i);
                    end else begin
                        idx_q.push_back(s_decrypt ? (ROUNDS - 1) : 0);
                    end
                end
                if (rf_valid) begin
                    if (idx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rf_valid_unexpected: got rf_valid=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        ei = idx_q.pop_front();
                        chk("round_idx", 64'(round_idx), 64'(ei));
                        chk("rf_K", 64'(rf_K), 64'(subkeys[ei]));
                    end
                end
                if (prev_hold) begin
                    chk("m_valid_held", 64'(m_valid), 64'd1);
                    chk("m_L_stable", 64'(m_L), 64'(held_l));
                    chk("m_R_stable", 64'(m_R), 64'(held_r));
                end
                if (m_valid) begin
                    chk("s_ready_in_done", 64'(s_ready), 64'd0);
                    if (!prev_mv && rf_lat_max == 1 && exp_q.size() != 0)
                        chk("latency", 64'(cyc - exp_q[0].acc), 64'(2 * ROUNDS));
                    if (m_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL m_valid_unexpected: got output %h_%h expected none (cycle %0d)", m_L, m_R, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("m_L", 64'(m_L), 64'(e.l));
                            chk("m_R", 64'(m_R), 64'(e.r));
                            $display("block out: m_L=%h m_R=%h cycle %0d", m_L, m_R, cyc);
                        end
                        last_ml = m_L;
                        last_mr = m_R;
                    end
                end
                prev_hold = m_valid && !m_ready;
                prev_mv   = m_valid;
                held_l    = m_L;
                held_r    = m_R;
            end
        end
    end

    task automatic send(input logic [31:0] l, input logic [31:0] r, input logic dec);
        s_L       = l;
        s_R       = r;
        s_decrypt = dec;
        s_valid   = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                $display("block in: L=%h R=%h dec=%0d cycle %0d", l, r, dec, cyc);
                return;
            end
        end
        s_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL accept_timeout: got s_ready=0 expected 1 within 400 cycles");
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && s_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        idx_q.delete();
    endtask

    initial begin : main
        logic [63:0] key;
        logic [55:0] cd;
        logic [27:0] c, d;
        int          acc_prev, acc_now, mv_seen;
        logic        got;

        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_L       = '0;
        s_R       = '0;
        s_decrypt = 1'b0;
        acc_prev  = 0;
        acc_now   = 0;

        // Key schedule for key 133457799BBCDFF1
        key = 64'h133457799BBCDFF1;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rr = 0; rr < 16; rr++) begin
            for (int s = 0; s < SHIFTS[rr]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) subkeys[rr][47-i] = cd[56-PC2[i]];
        end

        // Reset state
        apply_reset();
        chk("rst_s_ready",   64'(s_ready),   64'd1);
        chk("rst_m_valid",   64'(m_valid),   64'd0);
        chk("rst_rf_valid",  64'(rf_valid),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_m_L",       64'(m_L),       64'd0);
        chk("rst_m_R",       64'(m_R),       64'd0);
        chk("rst_round_idx", 64'(round_idx), 64'd0);
        rst_n = 1'b1;

        // Known-answer encrypt, then decrypt of the pre-output back to the input
        send(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0);
        wait_drain();
        chk("kat_enc_m_L", 64'(last_ml), 64'h0A4CD995);
        chk("kat_enc_m_R", 64'(last_mr), 64'h43423234);
        send(last_ml, last_mr, 1'b1);
        wait_drain();
        chk("kat_dec_m_L", 64'(last_ml), 64'hCC00CCFF);
        chk("kat_dec_m_R", 64'(last_mr), 64'hF0AAF0AA);

        // Backpressure: result held 10 cycles, a new request is refused meanwhile
        mr_force0 = 1'b1;
        send($urandom, $urandom, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = m_valid;
        end
        chk("bp_m_valid_reached", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        s_L = $urandom;
        s_R = $urandom;
        s_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        s_valid   = 1'b0;
        mr_force0 = 1'b0;
        m_ready   = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_s_ready", 64'(s_ready), 64'd1);
        chk("bp_release_m_valid", 64'(m_valid), 64'd0);

        // Reset in the middle of round 7
        send($urandom, $urandom, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = rf_valid && (round_idx == 4'd7);
        end
        chk("midrst_round7_reached", 64'(got), 64'd1);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        idx_q.delete();
        chk("midrst_busy",     64'(busy),     64'd0);
        chk("midrst_rf_valid", 64'(rf_valid), 64'd0);
        chk("midrst_m_valid",  64'(m_valid),  64'd0);
        chk("midrst_s_ready",  64'(s_ready),  64'd1);
        rst_n = 1'b1;
        mv_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (m_valid) mv_seen++;
        end
        chk("midrst_no_output", 64'(mv_seen), 64'd0);
        @(posedge clk);
        #1;
        send($urandom, $urandom, 1'b1);
        wait_drain();

        // Timeout: round function never answers
        rf_hang = 1'b1;
        send($urandom, $urandom, 1'b0);
        repeat (WAIT_MAX) @(posedge clk);
        #1;
        chk("to_busy_last_wait", 64'(busy), 64'd1);
        chk("to_err_not_yet",    64'(err),  64'd0);
        @(posedge clk);
        #1;
        chk("to_err",     64'(err),     64'd1);
        chk("to_s_ready", 64'(s_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("to_err_sticky", 64'(err), 64'd1);
        rf_hang = 1'b0;
        send($urandom, $urandom, 1'b0);
        chk("to_err_cleared", 64'(err), 64'd0);
        wait_drain();

        // Back-to-back: s_valid held high across three blocks
        s_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            s_L       = $urandom;
            s_R       = $urandom;
            s_decrypt = 1'(b & 1);
            got = 1'b0;
            for (int n = 0; n < 200 && !got; n++) begin
                @(negedge clk);
                if (s_ready) begin
                    @(posedge clk);
                    #1;
                    acc_now = cyc;
                    got = 1'b1;
                end
            end
            chk("b2b_accept", 64'(got), 64'd1);
            if (b > 0) begin
                checks++;
                if ((acc_now - acc_prev) < 2 * ROUNDS + 1 || (acc_now - acc_prev) > 2 * ROUNDS + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing: got %0d cycles expected %0d..%0d",
                             acc_now - acc_prev, 2 * ROUNDS + 1, 2 * ROUNDS + 2);
                end
            end
            acc_prev = acc_now;
        end
        s_valid = 1'b0;
        wait_drain();

        // Random blocks, random round-function latency, random backpressure
        rf_lat_max = WAIT_MAX;
        mr_rand    = 1'b1;
        stray_en   = 1'b1;
        for (int b = 0; b < 20; b++) begin
            send($urandom, $urandom, 1'($urandom_range(1, 0)));
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
        end
        wait_drain();
        mr_rand  = 1'b0;
        stray_en = 1'b0;

        chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("final_idx_q_empty", 64'(idx_q.size()), 64'd0);
        chk("final_err_clear",   64'(err),          64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
